mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) line-fill and writeback arbiter onto a single 64-bit burst memory port.
// Lines are 256 bits moved as four 64-bit beats; contention alternates between ports.
module mem_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_read,
  input  logic [31:0]  i_addr,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_addr,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [2:0] {StIdle, StIRd, StDRd, StDWr, StDone} state_e;

  state_e       r_state;
  state_e       w_state_next;
  logic [1:0]   r_cnt;
  logic         r_last_d;
  logic [31:0]  r_addr;
  logic [255:0] r_wdata;
  logic [255:0] r_i_line;
  logic [255:0] r_d_line;

  logic w_i_req;
  logic w_d_req;
  logic w_grant;
  logic w_grant_d;
  logic w_burst;
  logic w_beat;
  logic w_last_beat;

  always_comb begin
    w_i_req     = i_read;
    w_d_req     = d_read | d_write;
    w_grant     = (r_state == StIdle) & (w_i_req | w_d_req);
    // On contention the port that was not served last wins.
    w_grant_d   = w_d_req & (~w_i_req | ~r_last_d);
    w_burst     = (r_state == StIRd) | (r_state == StDRd) | (r_state == StDWr);
    w_beat      = w_burst & mem_resp;
    w_last_beat = w_beat & (r_cnt == 2'd3);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_grant) begin
          if (w_grant_d) w_state_next = d_write ? StDWr : StDRd;
          else           w_state_next = StIRd;
        end
      end
      StIRd, StDRd, StDWr: begin
        if (w_last_beat) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= 2'd0;
      r_last_d <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 256'd0;
      r_i_line <= 256'd0;
      r_d_line <= 256'd0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_last_d <= w_grant_d;
        r_addr   <= w_grant_d ? {d_addr[31:5], 5'd0} : {i_addr[31:5], 5'd0};
        if (w_grant_d && d_write) r_wdata <= d_wdata;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 2'd1;
        if (r_state == StIRd) r_i_line[{r_cnt, 6'd0} +: 64] <= mem_rdata;
        if (r_state == StDRd) r_d_line[{r_cnt, 6'd0} +: 64] <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_read  = (r_state == StIRd) | (r_state == StDRd);
    mem_write = (r_state == StDWr);
    mem_addr  = r_addr;
    mem_wdata = r_wdata[{r_cnt, 6'd0} +: 64];
    i_resp    = (r_state == StDone) & ~r_last_d;
    d_resp    = (r_state == StDone) & r_last_d;
    i_rdata   = r_i_line;
    d_rdata   = r_d_line;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a beat-level memory model serves bursts, and monitors
// compare addresses, write beats and completed lines against expectations queued at issue.
module tb_mem_arbiter;

  logic         clk;
  logic         reset;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [255:0] line;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
  } burst_t;

  resp_t        exp_resp[$];
  burst_t       exp_burst[$];
  logic [63:0]  exp_wbeat[$];
  logic [255:0] mem_model [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int tb_beat  = 0;
  int wait_after = -1;
  int wait_n     = 0;
  int wait_left  = 0;

  localparam logic [255:0] LineA = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                                    64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
  localparam logic [255:0] LineB = {64'hB3B3_0000_B3B3_0003, 64'hB2B2_0000_B2B2_0002,
                                    64'hB1B1_0000_B1B1_0001, 64'hB0B0_0000_B0B0_0000};
  localparam logic [255:0] LineC = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                                    64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
  localparam logic [255:0] Line1234 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LineWr = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] LineE = {64'hE3E3_0123_4567_89AB, 64'hE2E2_0123_4567_89AB,
                                    64'hE1E1_0123_4567_89AB, 64'hE0E0_0123_4567_89AB};
  localparam logic [255:0] LineF = {64'hF3F3_FEDC_BA98_7654, 64'hF2F2_FEDC_BA98_7654,
                                    64'hF1F1_FEDC_BA98_7654, 64'hF0F0_FEDC_BA98_7654};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_d, input bit wr, input logic [31:0] addr,
                          input logic [255:0] data);
    resp_t  r;
    burst_t b;
    r.is_d = is_d;
    r.wr   = wr;
    r.line = data;
    b.addr = {addr[31:5], 5'd0};
    b.wr   = wr;
    exp_resp.push_back(r);
    exp_burst.push_back(b);
    if (wr) begin
      for (int k = 0; k < 4; k++) exp_wbeat.push_back(data[k*64 +: 64]);
    end else begin
      mem_model[b.addr] = data;
    end
  endtask

  // Returns the number of clock edges seen until the port's resp is observed.
  task automatic wait_resp(input bit is_d, input string name, output int lat);
    lat = 0;
    while (!(is_d ? d_resp : i_resp) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no resp after %0d cycles, required a resp", name, lat);
    end
  endtask

  task automatic txn(input bit is_d, input bit wr, input bit rd, input logic [31:0] addr,
                     input logic [255:0] data, input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    push_exp(is_d, wr, addr, data);
    if (is_d) begin
      d_read = rd; d_write = wr; d_addr = addr; d_wdata = data;
    end else begin
      i_read = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    chk({name, "_busy"}, 256'(mem_read | mem_write), 256'(1));
    // Burst must be immune to input changes after the grant.
    i_addr  = 32'hFFFF_FFE4;
    d_addr  = 32'hFFFF_FFE8;
    d_wdata = {8{32'hDEAD_BEEF}};
    wait_resp(is_d, name, lat);
    chk({name, "_latency"}, 256'(lat + 1), 256'(exp_lat));
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  // Memory model: consume beats on the edge, then schedule the next beat just after it.
  always @(posedge clk) begin
    if (!reset && mem_resp && (mem_read || mem_write)) begin
      if (tb_beat == 0) begin
        if (exp_burst.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_burst: got burst at %h, required none", mem_addr);
        end else begin
          burst_t b;
          b = exp_burst.pop_front();
          chk("mem_addr", 256'(mem_addr), 256'(b.addr));
          chk("mem_write_kind", 256'(mem_write), 256'(b.wr));
          chk("mem_read_kind", 256'(mem_read), 256'(!b.wr));
        end
      end
      if (mem_write) begin
        if (exp_wbeat.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wbeat: got %h, required no write beat", mem_wdata);
        end else begin
          chk("mem_wdata", 256'(mem_wdata), 256'(exp_wbeat.pop_front()));
        end
      end
      tb_beat++;
    end
    #1;
    if (reset || !(mem_read || mem_write)) begin
      tb_beat   = 0;
      mem_resp  = 1'b0;
      wait_left = wait_n;
    end else if (tb_beat == wait_after + 1 && wait_left > 0) begin
      mem_resp  = 1'b0;
      wait_left--;
    end else begin
      logic [255:0] line;
      line      = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 256'd0;
      mem_resp  = 1'b1;
      mem_rdata = line[tb_beat*64 +: 64];
    end
  end

  always @(negedge clk) begin
    if (!reset && (i_resp || d_resp)) begin
      chk("one_resp", 256'(i_resp & d_resp), 256'(0));
      if (exp_resp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b, required none", i_resp, d_resp);
      end else begin
        resp_t e;
        e = exp_resp.pop_front();
        chk("resp_port", 256'(d_resp), 256'(e.is_d));
        if (!e.wr) chk(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? d_rdata : i_rdata, e.line);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 256'd0;
    mem_resp = 1'b0; mem_rdata = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read", 256'(mem_read), 256'(0));
    chk("rst_mem_write", 256'(mem_write), 256'(0));
    chk("rst_resp", 256'({i_resp, d_resp}), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr), 256'(0));
    chk("rst_i_rdata", i_rdata, 256'd0);
    chk("rst_d_rdata", d_rdata, 256'd0);
    reset = 1'b0;

    // Contention after reset: dcache first; a renewed dcache request then loses to icache.
    @(negedge clk);
    push_exp(1'b1, 1'b0, 32'h0000_0100, LineA);
    push_exp(1'b0, 1'b0, 32'h0000_2040, LineB);
    d_read = 1'b1; d_addr = 32'h0000_0100;
    i_read = 1'b1; i_addr = 32'h0000_2040;
    wait_resp(1'b1, "pair_d1", lat);
    d_read = 1'b0;
    @(negedge clk);
    push_exp(1'b1, 1'b0, 32'h0000_031F, LineC);
    d_read = 1'b1; d_addr = 32'h0000_031F;
    wait_resp(1'b0, "pair_i", lat);
    chk("d_rdata_hold", d_rdata, LineA);
    i_read = 1'b0;
    wait_resp(1'b1, "pair_d2", lat);
    d_read = 1'b0;

    txn(1'b0, 1'b0, 1'b1, 32'h0000_0064, Line1234, 5, "iread64");
    chk("d_rdata_hold2", d_rdata, LineC);
    txn(1'b1, 1'b1, 1'b0, 32'h0000_1000, LineWr, 5, "dwrite");
    chk("i_rdata_hold", i_rdata, Line1234);
    txn(1'b1, 1'b0, 1'b1, 32'h0000_4000, LineE, 5, "dread_nowait");
    wait_after = 1;
    wait_n     = 2;
    txn(1'b1, 1'b0, 1'b1, 32'h0000_5008, LineF, 7, "dread_wait");
    wait_after = -1;
    wait_n     = 0;
    txn(1'b1, 1'b1, 1'b1, 32'h0000_6000, LineB, 5, "drdwr");

    // Reset after three beats of a read: burst aborts with no resp.
    @(negedge clk);
    begin
      burst_t b;
      b.addr = 32'h0000_7000;
      b.wr   = 1'b0;
      exp_burst.push_back(b);
      mem_model[32'h0000_7000] = LineC;
    end
    d_read = 1'b1; d_addr = 32'h0000_7000;
    lat = 0;
    while (tb_beat < 3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_reached_beat3", 256'(tb_beat), 256'(3));
    reset = 1'b1; d_read = 1'b0;
    @(negedge clk);
    chk("abort_mem_read", 256'(mem_read), 256'(0));
    chk("abort_d_rdata", d_rdata, 256'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_resp", 256'({i_resp, d_resp}), 256'(0));
    txn(1'b1, 1'b0, 1'b1, 32'h0000_8000, LineA, 5, "post_reset");

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", 256'(exp_resp.size()), 256'(0));
    chk("burst_queue_empty", 256'(exp_burst.size()), 256'(0));
    chk("wbeat_queue_empty", 256'(exp_wbeat.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
